// File: rtl/mod_updown_cntr.sv
// Synchronous up/down counter and divider with a programmable terminal value.
// It also has parallel load, a terminal-count flag and a registered divide-by-2*(term_val+1) output.
module mod_updown_cntr #(
    parameter int unsigned      WIDTH   = 3,
    parameter logic [WIDTH-1:0] RST_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up_dn,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] term_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             div_out
);

    logic [WIDTH-1:0] count_q, count_d;
    logic             div_q, div_d;
    logic             wrap;

    // Up mode uses >= so that an out-of-range count (above term_val) wraps at once.
    assign wrap = en & ~load & (up_dn ? (count_q >= term_val) : (count_q == '0));

    // NOTE: every next-state signal gets its hold value first, so no path can infer a latch.
    always_comb begin
        count_d = count_q;
        div_d   = div_q;
        if (load) begin
            count_d = load_val;
        end else if (en) begin
            if (wrap) begin
                count_d = up_dn ? '0 : term_val;
                div_d   = ~div_q;
            end else begin
                count_d = up_dn ? count_q + WIDTH'(1) : count_q - WIDTH'(1);
            end
        end
    end

    // NOTE: use non-blocking assignments here, so all flops update together from their pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= RST_VAL;
            div_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            div_q   <= div_d;
        end
    end

    assign q       = count_q;
    assign tc      = wrap;
    assign div_out = div_q;

endmodule

// File: tb/tb_mod_updown_cntr.sv
// Self-checking bench for mod_updown_cntr (WIDTH=3, RST_VAL=0).
// Directed scenarios are followed by random traffic, and everything is compared with an arithmetic reference model.
module tb_mod_updown_cntr;

    localparam int W = 3;

    logic         clk, reset, en, up_dn, load;
    logic [W-1:0] load_val, term_val, q;
    logic         tc, div_out;

    int m_q;
    bit m_div;
    int n_pass, n_total;

    mod_updown_cntr #(.WIDTH(W), .RST_VAL(3'd0)) dut (
        .clk(clk), .reset(reset), .en(en), .up_dn(up_dn), .load(load),
        .load_val(load_val), .term_val(term_val), .q(q), .tc(tc), .div_out(div_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    endtask

    // The model follows the behavioural rules directly: load wins; otherwise wrap at the ends, else step by one.
    function automatic bit model_tc(bit e, bit u, bit l, int tv);
        return e && !l && (u ? (m_q >= tv) : (m_q == 0));
    endfunction

    task automatic model_step(bit e, bit u, bit l, int lv, int tv);
        if (l) m_q = lv;
        else if (e) begin
            if (model_tc(e, u, l, tv)) begin
                m_q   = u ? 0 : tv;
                m_div = !m_div;
            end else begin
                m_q = u ? (m_q + 1) % 8 : m_q - 1;
            end
        end
    endtask

    // Drives the inputs shortly after a rising edge, checks tc, then clocks and checks the registered outputs.
    task automatic cycle(input bit e, input bit u, input bit l, input int lv, input int tv, input string tag);
        en = e; up_dn = u; load = l; load_val = W'(lv); term_val = W'(tv);
        #1;
        check({tag, "_tc"}, 32'(tc), 32'(model_tc(e, u, l, tv)));
        @(posedge clk);
        model_step(e, u, l, lv, tv);
        #1;
        check({tag, "_q"}, 32'(q), 32'(m_q));
        check({tag, "_div"}, 32'(div_out), 32'(m_div));
    endtask

    initial begin
        n_pass = 0; n_total = 0;
        reset = 1'b0; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0; term_val = 3'd7;
        #12;
        check("rst_q", 32'(q), 32'd0);
        check("rst_div", 32'(div_out), 32'd0);
        check("rst_tc", 32'(tc), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        m_q = 0; m_div = 0;
        @(posedge clk); #1;

        for (int i = 0; i < 16; i++) cycle(1, 1, 0, 0, 7, "up7");
        check("up7_end_div", 32'(div_out), 32'd0);

        for (int i = 0; i < 10; i++) cycle(1, 0, 0, 0, 4, "dn4");

        cycle(0, 1, 1, 5, 5, "ld5");
        cycle(1, 1, 1, 7, 5, "ld7");
        check("ld7_q", 32'(q), 32'd7);
        cycle(1, 1, 0, 0, 5, "oor_wrap");
        check("oor_wrap_q", 32'(q), 32'd0);

        cycle(0, 1, 1, 2, 3, "en_ld2");
        cycle(1, 1, 0, 0, 3, "en_a");
        cycle(0, 1, 0, 0, 3, "en_b");
        cycle(0, 1, 0, 0, 3, "en_c");
        cycle(1, 1, 0, 0, 3, "en_d");
        check("en_d_q", 32'(q), 32'd0);

        cycle(1, 1, 1, 5, 7, "ar_ld5");
        cycle(1, 1, 0, 0, 7, "ar_up6");
        #2 reset = 1'b0;
        #1;
        m_q = 0; m_div = 0;
        check("async_q", 32'(q), 32'd0);
        check("async_div", 32'(div_out), 32'd0);
        @(posedge clk); #1;
        check("async_hold_q", 32'(q), 32'd0);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) cycle(1, 1, 0, 0, 7, "resume");
        check("resume_q", 32'(q), 32'd3);

        for (int i = 0; i < 8; i++) cycle(1, 1, 0, 0, 0, "tv0_up");
        for (int i = 0; i < 4; i++) cycle(1, 0, 0, 0, 0, "tv0_dn");

        for (int i = 0; i < 400; i++) begin
            cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, $urandom_range(0, 9) == 0,
                  $urandom_range(0, 7), (i % 50 < 40) ? 6 : $urandom_range(0, 7), "rnd");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/mod_updown_cntr.md
Name: mod_updown_cntr

Overview:
- Parametrised, fully synchronous successor to the 3-bit ripple counter. All bits share one clock, so there is no ripple skew.
- Adds programmable terminal value, up/down counting, count enable, parallel load, terminal-count flag and a divided-clock output.
- Used as the general counter/divider primitive in the counters-and-dividers library. Downstream logic uses div_out as an enable or divided reference.

Parameters:
WIDTH, 3, counter width in bits (>=1)
RST_VAL, 0, value loaded into q on reset (WIDTH bits)

Ports:
clk  input  1  single clock; all state updates on rising edge
reset  input  1  asynchronous, active-low reset (0 = reset asserted)
en  input  1  count enable; count advances only when high
up_dn  input  1  1 = count up, 0 = count down; sampled every cycle
load  input  1  synchronous parallel load, highest priority after reset
load_val  input  WIDTH  value written to q when load=1
term_val  input  WIDTH  terminal value; count range is 0..term_val
q  output  WIDTH  current count (registered)
tc  output  1  terminal-count flag (combinational from q, en, up_dn, term_val)
div_out  output  1  divided output; toggles on every wrap (registered)

Behaviour:
- Reset (reset=0, asynchronous, independent of clk): q=RST_VAL, div_out=0. reset is released synchronously by the surrounding design; the block adds no synchronizer.
- Priority per rising edge: reset > load > en > hold.
- load=1: q<=load_val next edge, regardless of en or up_dn. div_out is unchanged. Wrap is suppressed even if tc=1 that cycle.
- en=0, load=0: q and div_out hold.
- en=1, load=0, up_dn=1:
  - q>=term_val: q<=0 (wrap).
  - Otherwise: q<=q+1.
- en=1, load=0, up_dn=0:
  - q==0: q<=term_val (wrap).
  - Otherwise: q<=q-1.
- Out-of-range values (q>term_val, e.g. after a load or a term_val change):
  - Up mode wraps to 0 on the next enabled edge.
  - Down mode decrements normally until it reaches 0, then wraps to term_val.
- tc = en & ~load & ((up_dn & q>=term_val) | (~up_dn & q==0)). tc is high exactly in the cycle whose edge performs a wrap. No registered latency.
- div_out toggles on every edge where a wrap occurs, i.e. where tc=1. Period = 2*(term_val+1) enabled cycles, 50% duty when en is held high.
- term_val=0: q stays 0, tc=1 on every enabled cycle, div_out = clk/2.
- term_val=2^WIDTH-1: free-running full-range counter. No overflow beyond WIDTH bits; arithmetic is modulo 2^WIDTH but the wrap rule always applies first.
- up_dn change mid-count: takes effect on the same edge, with no extra state. Example: up at q=5 then switch to down gives 4 next.
- term_val change mid-count: takes effect immediately in the wrap compare.
- Reset asserted mid-count: q and div_out clear immediately (asynchronous). Counting resumes from RST_VAL on the first edge after release.
- No latches, no derived/gated clocks internally; div_out is a data signal from a flop.

Test Plan:
- WIDTH=3, term_val=7, up_dn=1, en=1 for 16 cycles from reset -> q=0,1..7,0..7:
  - tc high when q=7.
  - div_out toggles 0->1 at 8th edge, 1->0 at 16th edge.
- term_val=4, up_dn=0, en=1, start q=0 -> q: 4,3,2,1,0,4; tc high in each cycle q=0; div_out period 10 clocks.
- term_val=5, load=1 load_val=7 with en=1 and q=5 -> q=7, div_out unchanged, tc=0 that cycle. Next up edge q=0 with tc=1 and div_out toggling.
- en toggled 1,0,0,1 with term_val=3 up from q=2 -> q=3,3,3,0. tc low while en=0, high at q=3 en=1.
- Assert reset=0 asynchronously mid-cycle at q=6 (RST_VAL=0) -> q=0, div_out=0 before next clk edge. Release then count resumes 1,2,...
- term_val=0, en=1 -> q stays 0, tc constant 1, div_out toggles every clock.
